// File: rtl/msrh_conf_pkg.sv
// Core-wide configuration constants shared by the scheduler and commit logic.
package msrh_conf_pkg;
  localparam int DISP_SIZE = 4;
endpackage

// File: rtl/msrh_pkg.sv
// Shared types for commit notification between the commit tracker and scheduler entries.
package msrh_pkg;
  // Wide enough for any supported tracker depth; narrower IDs are zero-extended.
  localparam int CMT_ID_MAX_W = 8;

  typedef logic [3:0] except_t;

  typedef struct packed {
    logic                                 commit;
    logic [CMT_ID_MAX_W-1:0]              cmt_id;
    logic [msrh_conf_pkg::DISP_SIZE-1:0]  grp_id;
    logic                                 flush_valid;
    logic                                 all_dead;
    logic                                 except_valid;
    except_t                              except_type;
  } commit_blk_t;
endpackage

// File: rtl/msrh_commit_gen.sv
// In-order completion tracker: allocates commit IDs per dispatch group, collects done
// reports, retires groups in order and drains younger groups after an exception.
module msrh_commit_gen
  import msrh_pkg::*;
#(
  parameter  int CMT_ENTRY_SIZE = 16,
  parameter  int DONE_PORTS     = 4,
  localparam int CMT_ID_W       = $clog2(CMT_ENTRY_SIZE) + 1,
  localparam int DISP_SIZE      = msrh_conf_pkg::DISP_SIZE
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_disp_valid,
  input  logic [DISP_SIZE-1:0] i_disp_grp_id,
  output logic                 o_disp_ready,
  output logic [CMT_ID_W-1:0]  o_disp_cmt_id,
  input  logic [DONE_PORTS-1:0] i_done_valid,
  input  logic [CMT_ID_W-1:0]  i_done_cmt_id [DONE_PORTS],
  input  logic [DISP_SIZE-1:0] i_done_grp_id [DONE_PORTS],
  input  logic [DONE_PORTS-1:0] i_done_except_valid,
  input  except_t              i_done_except_type [DONE_PORTS],
  output commit_blk_t          o_commit
);

  localparam int IDX_W = CMT_ID_W - 1;

  typedef enum logic {RUN, DRAIN} mode_t;

  mode_t                     r_mode, w_mode_nxt;
  logic [CMT_ID_W-1:0]       r_head, r_tail;
  logic [CMT_ENTRY_SIZE-1:0] r_valid, w_valid_nxt;

  logic [CMT_ID_W-1:0]       r_cmt_id    [CMT_ENTRY_SIZE];
  logic [DISP_SIZE-1:0]      r_grp_mask  [CMT_ENTRY_SIZE];
  logic [DISP_SIZE-1:0]      r_done_mask [CMT_ENTRY_SIZE];
  logic [CMT_ENTRY_SIZE-1:0] r_exc_valid;
  logic [DISP_SIZE-1:0]      r_exc_slot  [CMT_ENTRY_SIZE];
  except_t                   r_exc_type  [CMT_ENTRY_SIZE];

  logic [DISP_SIZE-1:0]      w_done_set     [CMT_ENTRY_SIZE];
  logic [CMT_ENTRY_SIZE-1:0] w_exc_valid_nxt;
  logic [DISP_SIZE-1:0]      w_exc_slot_nxt [CMT_ENTRY_SIZE];
  except_t                   w_exc_type_nxt [CMT_ENTRY_SIZE];

  logic [IDX_W-1:0]     w_head_idx, w_tail_idx;
  logic                 w_full, w_alloc, w_retire;
  logic [DISP_SIZE-1:0] w_h_grp, w_h_done, w_h_older, w_h_grp_old;
  logic                 w_normal_rdy, w_flush_rdy;

  assign w_head_idx = r_head[IDX_W-1:0];
  assign w_tail_idx = r_tail[IDX_W-1:0];
  assign w_full     = (w_head_idx == w_tail_idx) && (r_head[IDX_W] != r_tail[IDX_W]);

  assign o_disp_ready  = !w_full && (r_mode == RUN);
  assign o_disp_cmt_id = r_tail;
  assign w_alloc       = i_disp_valid && o_disp_ready;

  // Slots at or below the recorded (one-hot) exception slot must be done before flushing.
  assign w_h_grp     = r_grp_mask[w_head_idx];
  assign w_h_done    = r_done_mask[w_head_idx];
  assign w_h_older   = r_exc_slot[w_head_idx] | (r_exc_slot[w_head_idx] - DISP_SIZE'(1));
  assign w_h_grp_old = w_h_grp & w_h_older;

  assign w_normal_rdy = r_valid[w_head_idx] && !r_exc_valid[w_head_idx] && (w_h_done == w_h_grp);
  assign w_flush_rdy  = r_valid[w_head_idx] && r_exc_valid[w_head_idx] &&
                        ((w_h_done & w_h_grp_old) == w_h_grp_old);

  always_comb begin
    w_mode_nxt = r_mode;
    w_retire   = 1'b0;
    o_commit   = '0;
    case (r_mode)
      RUN: begin
        if (w_normal_rdy) begin
          o_commit.commit = 1'b1;
          o_commit.cmt_id = CMT_ID_MAX_W'(r_head);
          o_commit.grp_id = w_h_grp;
          w_retire        = 1'b1;
        end else if (w_flush_rdy) begin
          o_commit.commit       = 1'b1;
          o_commit.cmt_id       = CMT_ID_MAX_W'(r_head);
          o_commit.grp_id       = w_h_grp_old;
          o_commit.flush_valid  = 1'b1;
          o_commit.except_valid = 1'b1;
          o_commit.except_type  = r_exc_type[w_head_idx];
          w_mode_nxt            = DRAIN;
        end
      end
      DRAIN: begin
        if (r_head != r_tail) begin
          o_commit.commit   = 1'b1;
          o_commit.cmt_id   = CMT_ID_MAX_W'(r_head);
          o_commit.grp_id   = w_h_grp;
          o_commit.all_dead = 1'b1;
          w_retire          = 1'b1;
          if ((r_head + CMT_ID_W'(1)) == r_tail) w_mode_nxt = RUN;
        end else begin
          w_mode_nxt = RUN;
        end
      end
      default: w_mode_nxt = RUN;
    endcase
  end

  // Merge all done ports per entry; the lowest excepting slot wins, including the recorded one.
  always_comb begin
    for (int e = 0; e < CMT_ENTRY_SIZE; e++) begin
      w_done_set[e]      = '0;
      w_exc_valid_nxt[e] = r_exc_valid[e];
      w_exc_slot_nxt[e]  = r_exc_slot[e];
      w_exc_type_nxt[e]  = r_exc_type[e];
      for (int p = 0; p < DONE_PORTS; p++) begin
        if ((r_mode == RUN) && i_done_valid[p] && r_valid[e] &&
            (i_done_cmt_id[p] == r_cmt_id[e]) && |(i_done_grp_id[p] & r_grp_mask[e])) begin
          w_done_set[e] = w_done_set[e] | (i_done_grp_id[p] & r_grp_mask[e]);
          if (i_done_except_valid[p] &&
              (!w_exc_valid_nxt[e] || (i_done_grp_id[p] < w_exc_slot_nxt[e]))) begin
            w_exc_valid_nxt[e] = 1'b1;
            w_exc_slot_nxt[e]  = i_done_grp_id[p];
            w_exc_type_nxt[e]  = i_done_except_type[p];
          end
        end
      end
    end
  end

  always_comb begin
    w_valid_nxt = r_valid;
    if (w_alloc)  w_valid_nxt[w_tail_idx] = 1'b1;
    if (w_retire) w_valid_nxt[w_head_idx] = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_mode  <= RUN;
      r_head  <= '0;
      r_tail  <= '0;
      r_valid <= '0;
    end else begin
      r_mode  <= w_mode_nxt;
      r_valid <= w_valid_nxt;
      if (w_alloc)  r_tail <= r_tail + CMT_ID_W'(1);
      if (w_retire) r_head <= r_head + CMT_ID_W'(1);
    end
  end

  // Entry payload is qualified by r_valid, so it needs no reset.
  always_ff @(posedge i_clk) begin
    for (int e = 0; e < CMT_ENTRY_SIZE; e++) begin
      if (w_alloc && (w_tail_idx == IDX_W'(e))) begin
        r_cmt_id[e]    <= r_tail;
        r_grp_mask[e]  <= i_disp_grp_id;
        r_done_mask[e] <= '0;
        r_exc_valid[e] <= 1'b0;
        r_exc_slot[e]  <= '0;
        r_exc_type[e]  <= '0;
      end else begin
        r_done_mask[e] <= r_done_mask[e] | w_done_set[e];
        r_exc_valid[e] <= w_exc_valid_nxt[e];
        r_exc_slot[e]  <= w_exc_slot_nxt[e];
        r_exc_type[e]  <= w_exc_type_nxt[e];
      end
    end
  end

endmodule

// File: tb/tb_msrh_commit_gen.sv
// Directed bench for msrh_commit_gen with a scoreboard of expected commit notifications.
module tb_msrh_commit_gen;
  import msrh_pkg::*;

  localparam int P   = 4;
  localparam int IDW = 5;
  localparam int DS  = msrh_conf_pkg::DISP_SIZE;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            disp_valid = 1'b0;
  logic [DS-1:0]   disp_grp = '0;
  logic            disp_ready;
  logic [IDW-1:0]  disp_id;
  logic [P-1:0]    dv;
  logic [IDW-1:0]  did  [P];
  logic [DS-1:0]   dgrp [P];
  logic [P-1:0]    dexv;
  except_t         dext [P];
  commit_blk_t     cmt;

  int tests = 0;
  int fails = 0;
  commit_blk_t exp_q[$];

  always #5 clk = ~clk;

  msrh_commit_gen #(.CMT_ENTRY_SIZE(16), .DONE_PORTS(P)) dut (
    .i_clk              (clk),
    .i_reset_n          (rst_n),
    .i_disp_valid       (disp_valid),
    .i_disp_grp_id      (disp_grp),
    .o_disp_ready       (disp_ready),
    .o_disp_cmt_id      (disp_id),
    .i_done_valid       (dv),
    .i_done_cmt_id      (did),
    .i_done_grp_id      (dgrp),
    .i_done_except_valid(dexv),
    .i_done_except_type (dext),
    .o_commit           (cmt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic commit_blk_t mk(input int id, input logic [DS-1:0] g, input logic fl,
                                     input logic dead, input logic exv, input except_t et);
    commit_blk_t c;
    c = '0;
    c.commit       = 1'b1;
    c.cmt_id       = 8'(id);
    c.grp_id       = g;
    c.flush_valid  = fl;
    c.all_dead     = dead;
    c.except_valid = exv;
    c.except_type  = et;
    return c;
  endfunction

  task automatic mon();
    commit_blk_t e;
    if (cmt.commit) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_commit", 32'(cmt), 32'h0);
      end else begin
        e = exp_q.pop_front();
        chk("commit_blk", 32'(cmt), 32'(e));
      end
    end else begin
      chk("idle_commit", 32'(cmt), 32'h0);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_done();
    dv   = '0;
    dexv = '0;
    for (int p = 0; p < P; p++) begin
      did[p]  = '0;
      dgrp[p] = '0;
      dext[p] = '0;
    end
  endtask

  task automatic set_done(input int p, input int id, input logic [DS-1:0] g,
                          input logic exv, input except_t et);
    dv[p]   = 1'b1;
    did[p]  = IDW'(id);
    dgrp[p] = g;
    dexv[p] = exv;
    dext[p] = et;
  endtask

  task automatic alloc(input logic [DS-1:0] g, input int id);
    chk("alloc_ready", 32'(disp_ready), 32'd1);
    chk("alloc_id", 32'(disp_id), 32'(id));
    disp_valid = 1'b1;
    disp_grp   = g;
    tick();
    disp_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_commit", 32'(cmt), 32'h0);
    chk("rst_ready", 32'(disp_ready), 32'd1);
    chk("rst_id", 32'(disp_id), 32'd0);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    clr_done();
    #1;
    do_reset();
    tick();

    // Basic two-slot group.
    alloc(4'b0011, 0);
    chk("disp_id_next", 32'(disp_id), 32'd1);
    set_done(0, 0, 4'b0001, 1'b0, 4'd0);
    set_done(1, 0, 4'b0010, 1'b0, 4'd0);
    exp_q.push_back(mk(0, 4'b0011, 1'b0, 1'b0, 1'b0, 4'd0));
    tick();
    clr_done();
    chk("basic_latency", 32'(cmt.commit), 32'd1);
    tick();

    // Fill, blocked allocation while full, freed entry reusable one cycle later, wrap.
    do_reset();
    tick();
    for (int i = 0; i < 16; i++) alloc(4'b0001, i);
    chk("full_ready", 32'(disp_ready), 32'd0);
    chk("full_tail", 32'(disp_id), 32'd16);
    disp_valid = 1'b1;
    disp_grp   = 4'b0001;
    set_done(0, 0, 4'b0001, 1'b0, 4'd0);
    exp_q.push_back(mk(0, 4'b0001, 1'b0, 1'b0, 1'b0, 4'd0));
    tick();
    clr_done();
    chk("full_commit", 32'(cmt.commit), 32'd1);
    chk("full_ready_commit", 32'(disp_ready), 32'd0);
    tick();
    chk("ready_after_free", 32'(disp_ready), 32'd1);
    chk("wrap_id", 32'(disp_id), 32'd16);
    tick();
    disp_valid = 1'b0;
    chk("wrap_next_id", 32'(disp_id), 32'd17);
    chk("full_again", 32'(disp_ready), 32'd0);
    for (int i = 1; i <= 16; i++) begin
      set_done(0, i, 4'b0001, 1'b0, 4'd0);
      exp_q.push_back(mk(i, 4'b0001, 1'b0, 1'b0, 1'b0, 4'd0));
      tick();
    end
    clr_done();
    tick();
    tick();
    chk("stream_drained", 32'(exp_q.size()), 32'd0);

    // Out-of-order completion retires in order.
    do_reset();
    tick();
    alloc(4'b0001, 0);
    alloc(4'b0001, 1);
    alloc(4'b0001, 2);
    set_done(0, 1, 4'b0001, 1'b0, 4'd0);
    set_done(1, 2, 4'b0001, 1'b0, 4'd0);
    tick();
    clr_done();
    chk("ooo_wait_head", 32'(cmt.commit), 32'd0);
    set_done(0, 0, 4'b0001, 1'b0, 4'd0);
    for (int k = 0; k < 3; k++) exp_q.push_back(mk(k, 4'b0001, 1'b0, 1'b0, 1'b0, 4'd0));
    tick();
    clr_done();
    for (int k = 0; k < 3; k++) begin
      chk("ooo_commit", 32'(cmt.commit), 32'd1);
      chk("ooo_id", 32'(cmt.cmt_id), 32'(k));
      tick();
    end
    chk("ooo_idle", 32'(cmt.commit), 32'd0);

    // Exception on slot 1 of group 0: flush then drain three groups.
    do_reset();
    tick();
    alloc(4'b1111, 0);
    alloc(4'b0001, 1);
    alloc(4'b0001, 2);
    set_done(0, 0, 4'b0001, 1'b0, 4'd0);
    set_done(1, 0, 4'b0010, 1'b1, 4'd5);
    exp_q.push_back(mk(0, 4'b0011, 1'b1, 1'b0, 1'b1, 4'd5));
    exp_q.push_back(mk(0, 4'b1111, 1'b0, 1'b1, 1'b0, 4'd0));
    exp_q.push_back(mk(1, 4'b0001, 1'b0, 1'b1, 1'b0, 4'd0));
    exp_q.push_back(mk(2, 4'b0001, 1'b0, 1'b1, 1'b0, 4'd0));
    tick();
    clr_done();
    chk("flush_visible", 32'(cmt.flush_valid), 32'd1);
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("drain_ready", 32'(disp_ready), 32'd0);
      chk("drain_dead", 32'(cmt.all_dead), 32'd1);
      tick();
    end
    chk("post_drain_ready", 32'(disp_ready), 32'd1);
    chk("post_drain_idle", 32'(cmt.commit), 32'd0);

    // Two ports except in one cycle: the older slot's cause wins.
    alloc(4'b0111, 3);
    set_done(0, 3, 4'b0100, 1'b1, 4'd7);
    set_done(1, 3, 4'b0010, 1'b1, 4'd3);
    set_done(2, 3, 4'b0001, 1'b0, 4'd0);
    exp_q.push_back(mk(3, 4'b0011, 1'b1, 1'b0, 1'b1, 4'd3));
    exp_q.push_back(mk(3, 4'b0111, 1'b0, 1'b1, 1'b0, 4'd0));
    tick();
    clr_done();
    tick();
    tick();

    // An older exception arriving later replaces the recorded one.
    alloc(4'b0111, 4);
    set_done(0, 4, 4'b0100, 1'b1, 4'd9);
    tick();
    clr_done();
    chk("override_wait", 32'(cmt.commit), 32'd0);
    set_done(0, 4, 4'b0010, 1'b1, 4'd4);
    set_done(1, 4, 4'b0001, 1'b0, 4'd0);
    exp_q.push_back(mk(4, 4'b0011, 1'b1, 1'b0, 1'b1, 4'd4));
    exp_q.push_back(mk(4, 4'b0111, 1'b0, 1'b1, 1'b0, 4'd0));
    tick();
    clr_done();
    tick();
    tick();

    // Reports to a slot outside the mask or to an unallocated entry are ignored.
    alloc(4'b0001, 5);
    set_done(0, 5, 4'b0010, 1'b0, 4'd0);
    set_done(1, 9, 4'b0001, 1'b0, 4'd0);
    tick();
    clr_done();
    chk("ignored_done", 32'(cmt.commit), 32'd0);
    set_done(0, 5, 4'b0001, 1'b0, 4'd0);
    exp_q.push_back(mk(5, 4'b0001, 1'b0, 1'b0, 1'b0, 4'd0));
    tick();
    clr_done();
    chk("accepted_done", 32'(cmt.commit), 32'd1);
    tick();

    // Reset in the middle of a drain.
    alloc(4'b1111, 6);
    alloc(4'b0001, 7);
    set_done(0, 6, 4'b0001, 1'b1, 4'd2);
    exp_q.push_back(mk(6, 4'b0001, 1'b1, 1'b0, 1'b1, 4'd2));
    exp_q.push_back(mk(6, 4'b1111, 1'b0, 1'b1, 1'b0, 4'd0));
    tick();
    clr_done();
    tick();
    tick();
    chk("mid_drain_dead", 32'(cmt.all_dead), 32'd1);
    chk("mid_drain_id", 32'(cmt.cmt_id), 32'd7);
    do_reset();
    tick();
    alloc(4'b0010, 0);
    set_done(0, 0, 4'b0010, 1'b0, 4'd0);
    exp_q.push_back(mk(0, 4'b0010, 1'b0, 1'b0, 1'b0, 4'd0));
    tick();
    clr_done();
    tick();
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/msrh_commit_gen.md
# msrh_commit_gen

In-order completion tracker and generator of the `msrh_pkg::commit_blk_t` notification consumed by every scheduler entry. It allocates one commit ID per dispatch group and collects per-slot done reports from the execution pipes. It retires groups in program order, one per cycle. On an exception it issues a flush commit, then drains every younger allocated group with `all_dead` commits so that dead scheduler entries return to INIT.

## Interface
- `CMT_ENTRY_SIZE`, default 16: tracker depth; power of two, ≥ 2.
- `DONE_PORTS`, default 4: number of done-report ports.
- Derived: `CMT_ID_W = $clog2(CMT_ENTRY_SIZE)+1`. The MSB is the wrap bit; the low bits are the entry index.
- `DISP_SIZE`: taken from `msrh_conf_pkg::DISP_SIZE`; not a parameter.

Ports (all synchronous to `i_clk`):
- `i_clk`  in  1  clock.
- `i_reset_n`  in  1  reset, asynchronous, active-low.
- `i_disp_valid`  in  1  dispatch group allocation request.
- `i_disp_grp_id`  in  DISP_SIZE  valid-slot mask of the group; must be nonzero when valid.
- `o_disp_ready`  out  1  allocation accepted this cycle.
- `o_disp_cmt_id`  out  CMT_ID_W  ID assigned to the group accepted this cycle (current tail).
- `i_done_valid`  in  DONE_PORTS  per-port done strobe.
- `i_done_cmt_id`  in  DONE_PORTS×CMT_ID_W  target group.
- `i_done_grp_id`  in  DONE_PORTS×DISP_SIZE  one-hot target slot.
- `i_done_except_valid`  in  DONE_PORTS  the slot raised an exception.
- `i_done_except_type`  in  DONE_PORTS×except_t  exception cause.
- `o_commit`  out  commit_blk_t  fields `commit`, `cmt_id`, `grp_id`, `flush_valid`, `all_dead`, `except_valid`, `except_type`.

## Operation
- Storage is a circular buffer with head and tail pointers of CMT_ID_W bits each.
  - Empty: head == tail.
  - Full: index bits equal and wrap bits differ.
- Per-entry state: `valid`, `grp_mask`, `done_mask`, `except_valid`, `except_slot` (one-hot), `except_type`.
- Modes: RUN and DRAIN.
- Allocation: `o_disp_ready = !full & mode==RUN`.
  - On `i_disp_valid & o_disp_ready`: write the tail entry with `grp_mask = i_disp_grp_id` and all other fields cleared, then increment tail.
- Done reports:
  - A report is accepted when the target entry is valid and the target slot bit is set in `grp_mask`. Otherwise it is ignored.
  - An accepted report sets the slot's `done_mask` bit.
  - An exception report records `except_slot` and `except_type` only if the entry has no recorded exception, or if the new slot is lower (older) than the recorded one.
  - Several ports may hit the same entry in one cycle; all bits are ORed, and the lowest excepting slot wins.
- RUN, head valid and no exception recorded: when `done_mask == grp_mask`, drive a normal commit: `commit=1`, `cmt_id=head`, `grp_id=grp_mask`, `flush_valid=0`, `all_dead=0`. Then invalidate head and increment it.
- RUN, head valid with an exception recorded: when every `grp_mask` slot at or below `except_slot` is done, drive a flush commit:
  - `commit=1`, `flush_valid=1`, `all_dead=0`, `except_valid=1`, `except_type`.
  - `grp_id` = `grp_mask` bits at or below `except_slot`.
  - Keep head unchanged and enter DRAIN.
  - Younger slots of the same group need not be done.
- DRAIN: each cycle, drive `commit=1`, `all_dead=1`, `flush_valid=0`, `cmt_id=head`, `grp_id=grp_mask` for the head entry (the flushed group first). Then invalidate head and increment it.
  - When head reaches tail, return to RUN. The first RUN cycle may allocate.
  - Done reports arriving during DRAIN are ignored.
- At most one commit per cycle. When no commit is driven, all `o_commit` fields are 0.

## Timing
- Reset, asynchronous: head = tail = 0, all entries invalid, mode RUN. Outputs: `o_commit` all 0, `o_disp_ready=1`, `o_disp_cmt_id=0`.
- `o_commit` is combinational from registered state only; it never depends on the same-cycle `i_done_*`.
- Latency:
  - The last done sampled at edge E gives `o_commit.commit=1` in the cycle after E.
  - A group allocated at edge E may receive done in the cycle after E.
- Back-to-back normal commits are allowed every cycle.
- DRAIN takes exactly N cycles for N allocated groups, counting the flushed one.
- Simultaneous allocate and commit in the same cycle is legal; when full, the freed entry is not reusable until the next cycle.
- Tail wrap toggles the MSB of `o_disp_cmt_id`; head uses the same wrap rule.
- Done and commit to the same head entry in one cycle: the done is ignored, because the entry is already complete.
- Reset asserted mid-DRAIN returns the block to the reset state immediately.

## Test plan
- Allocate group mask 4'b0011 (ID 0), done slots 0 and 1 in cycle 3 → commit cmt_id=0, grp_id=0011, flush_valid=0 in cycle 4; `o_disp_cmt_id`=1.
- Allocate 16 groups → `o_disp_ready=0`; commit ID 0 → ready=1 in the next cycle; the 17th group gets ID 16 (wrap bit set).
- Allocate IDs 0, 1, 2; done IDs 1 and 2 before ID 0 → commits occur in order 0, 1, 2 on consecutive cycles.
- Group 1111 at ID 0 with an exception on slot 1 and slot 0 done, IDs 1 and 2 allocated → flush commit grp_id=0011 with except_type, then all_dead commits for IDs 0, 1, 2 on 3 cycles, `o_disp_ready=0` throughout, ready=1 afterward.
- Two ports report exceptions on slots 2 and 1 of the same group in one cycle → the flush commit reports slot 1's except_type.
- Assert reset during DRAIN → `o_commit`=0 and `o_disp_cmt_id`=0 immediately; the next allocation gets ID 0.
